// File: rtl/genis_toplayici_if.sv
// Request/result handshake bundle for genis_toplayici.
// GENIS_TOPLAYICI_DOYUM_EN adds the doyum_i saturation request bit.
interface genis_toplayici_if;
  logic        gecerli_i;
  logic        hazir_o;
  logic [63:0] islec0_i;
  logic [63:0] islec1_i;
  logic        cikar_i;
`ifdef GENIS_TOPLAYICI_DOYUM_EN
  logic        doyum_i;
`endif
  logic        sonuc_gecerli_o;
  logic        sonuc_hazir_i;
  logic [63:0] sonuc_o;
  logic        elde_o;
  logic        tasma_o;
  logic        sifir_o;

  modport master (
`ifdef GENIS_TOPLAYICI_DOYUM_EN
    output doyum_i,
`endif
    output gecerli_i, islec0_i, islec1_i, cikar_i, sonuc_hazir_i,
    input  hazir_o, sonuc_gecerli_o, sonuc_o, elde_o, tasma_o, sifir_o
  );

  modport slave (
`ifdef GENIS_TOPLAYICI_DOYUM_EN
    input  doyum_i,
`endif
    input  gecerli_i, islec0_i, islec1_i, cikar_i, sonuc_hazir_i,
    output hazir_o, sonuc_gecerli_o, sonuc_o, elde_o, tasma_o, sifir_o
  );
endinterface

// File: rtl/genis_toplayici.sv
// 64-bit add/subtract built from one shared 32-bit prefix adder, low half then high half.
// GENIS_TOPLAYICI_DOYUM_EN enables signed saturation on overflow (doyum_i).

module toplayici (
  input  logic [31:0] islec0_i,
  input  logic [31:0] islec1_i,
  input  logic        carry_i,
  output logic [31:0] toplam_o,
  output logic        carry_o
);
  logic [31:0] p0, g, p, gn, pn;

  // Kogge-Stone: carry-in folded into bit 0 generate so g[i] is the carry into bit i+1
  always_comb begin
    p0 = islec0_i ^ islec1_i;
    g  = islec0_i & islec1_i;
    g[0] = g[0] | (p0[0] & carry_i);
    p  = p0;
    gn = '0;
    pn = '0;
    for (int l = 0; l < 5; l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < 32; i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
        pn[i] = p[i] & p[i - (1 << l)];
      end
      g = gn;
      p = pn;
    end
    toplam_o = p0 ^ {g[30:0], carry_i};
    carry_o  = g[31];
  end
endmodule

module genis_toplayici (
  input  logic               clk_i,
  input  logic               rstn_i,
  genis_toplayici_if.slave   bus
);
  typedef enum logic [1:0] {BOSTA, ALT, UST, CIKTI} durum_t;

  durum_t      durum;
  logic [63:0] a_q, b_q;
  logic        cin_q;
  logic        elde_ara_q;
  logic [31:0] alt_q;
  logic [63:0] sonuc_q;
  logic        elde_q, tasma_q, sifir_q, gecerli_q;
`ifdef GENIS_TOPLAYICI_DOYUM_EN
  logic        doyum_q;
`endif

  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        tasma_d;
  logic [63:0] sonuc_ham, sonuc_son;

  // Adder inputs held at zero outside the two compute states
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (durum)
      ALT: begin
        add_a   = a_q[31:0];
        add_b   = b_q[31:0];
        add_cin = cin_q;
      end
      UST: begin
        add_a   = a_q[63:32];
        add_b   = b_q[63:32];
        add_cin = elde_ara_q;
      end
      default: ;
    endcase
  end

  toplayici u_toplayici (
    .islec0_i (add_a),
    .islec1_i (add_b),
    .carry_i  (add_cin),
    .toplam_o (add_sum),
    .carry_o  (add_cout)
  );

  assign tasma_d   = (a_q[63] == b_q[63]) & (add_sum[31] != a_q[63]);
  assign sonuc_ham = {add_sum, alt_q};

`ifdef GENIS_TOPLAYICI_DOYUM_EN
  assign sonuc_son = (doyum_q & tasma_d)
                   ? (a_q[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF)
                   : sonuc_ham;
`else
  assign sonuc_son = sonuc_ham;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum      <= BOSTA;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      elde_ara_q <= 1'b0;
      alt_q      <= '0;
      sonuc_q    <= '0;
      elde_q     <= 1'b0;
      tasma_q    <= 1'b0;
      sifir_q    <= 1'b0;
      gecerli_q  <= 1'b0;
`ifdef GENIS_TOPLAYICI_DOYUM_EN
      doyum_q    <= 1'b0;
`endif
    end else begin
      case (durum)
        BOSTA: if (bus.gecerli_i) begin
          a_q   <= bus.islec0_i;
          b_q   <= bus.cikar_i ? ~bus.islec1_i : bus.islec1_i;
          cin_q <= bus.cikar_i;
`ifdef GENIS_TOPLAYICI_DOYUM_EN
          doyum_q <= bus.doyum_i;
`endif
          durum <= ALT;
        end
        ALT: begin
          alt_q      <= add_sum;
          elde_ara_q <= add_cout;
          durum      <= UST;
        end
        UST: begin
          sonuc_q   <= sonuc_son;
          elde_q    <= add_cout;
          tasma_q   <= tasma_d;
          sifir_q   <= (sonuc_son == 64'd0);
          gecerli_q <= 1'b1;
          durum     <= CIKTI;
        end
        CIKTI: if (bus.sonuc_hazir_i) begin
          gecerli_q <= 1'b0;
          durum     <= BOSTA;
        end
        default: durum <= BOSTA;
      endcase
    end
  end

  assign bus.hazir_o         = (durum == BOSTA);
  assign bus.sonuc_gecerli_o = gecerli_q;
  assign bus.sonuc_o         = sonuc_q;
  assign bus.elde_o          = elde_q;
  assign bus.tasma_o         = tasma_q;
  assign bus.sifir_o         = sifir_q;
endmodule

// File: tb/tb_genis_toplayici.sv
// Directed + random bench for genis_toplayici against a wide-integer arithmetic model.
module tb_genis_toplayici;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  genis_toplayici_if bus();
  genis_toplayici dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));

`ifdef GENIS_TOPLAYICI_DOYUM_EN
  localparam bit DOYUM_VAR = 1'b1;
`else
  localparam bit DOYUM_VAR = 1'b0;
`endif
  localparam logic signed [65:0] SMAX = 66'sd9223372036854775807;
  localparam logic signed [65:0] SMIN = -66'sd9223372036854775808;

  int checks = 0;
  int errors = 0;
  logic [63:0] e_sonuc;
  logic        e_elde, e_tasma, e_sifir;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact unsigned/signed integer results, then wrap or clamp
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic sub, input logic d,
                                output logic [63:0] r, output logic c,
                                output logic v, output logic z);
    logic [64:0] u;
    logic signed [65:0] sa, sb, s;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    if (sub) begin
      u = {1'b0, a} - {1'b0, b};
      c = (a >= b);
      s = sa - sb;
    end else begin
      u = {1'b0, a} + {1'b0, b};
      c = u[64];
      s = sa + sb;
    end
    v = (s > SMAX) || (s < SMIN);
    r = u[63:0];
    if (d && DOYUM_VAR && v) r = (s > 0) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
    z = (r == 64'd0);
  endfunction

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic sub, input logic d);
    bus.islec0_i = a;
    bus.islec1_i = b;
    bus.cikar_i  = sub;
`ifdef GENIS_TOPLAYICI_DOYUM_EN
    bus.doyum_i  = d;
`else
    if (d) bus.cikar_i = sub;
`endif
  endtask

  task automatic scramble();
    drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
  endtask

  // Entered right after the accept edge; checks latency then the result
  task automatic collect();
    @(negedge clk);
    bus.gecerli_i = 1'b0;
    scramble();
    chk("lat_alt", 64'(bus.sonuc_gecerli_o), 64'd0);
    @(negedge clk);
    chk("lat_ust", 64'(bus.sonuc_gecerli_o), 64'd0);
    @(negedge clk);
    chk("lat_valid", 64'(bus.sonuc_gecerli_o), 64'd1);
    chk("sonuc", bus.sonuc_o, e_sonuc);
    chk("elde",  64'(bus.elde_o),  64'(e_elde));
    chk("tasma", 64'(bus.tasma_o), 64'(e_tasma));
    chk("sifir", 64'(bus.sifir_o), 64'(e_sifir));
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sub, input logic d);
    @(negedge clk);
    drive(a, b, sub, d);
    bus.gecerli_i = 1'b1;
    chk("hazir_idle", 64'(bus.hazir_o), 64'd1);
    model(a, b, sub, d, e_sonuc, e_elde, e_tasma, e_sifir);
    @(posedge clk);
    collect();
  endtask

  task automatic pop(input int gecikme);
    for (int i = 0; i < gecikme; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.sonuc_gecerli_o), 64'd1);
      chk("hold_sonuc", bus.sonuc_o, e_sonuc);
    end
    bus.sonuc_hazir_i = 1'b1;
    @(negedge clk);
    bus.sonuc_hazir_i = 1'b0;
    chk("pop_valid", 64'(bus.sonuc_gecerli_o), 64'd0);
    chk("pop_hazir", 64'(bus.hazir_o), 64'd1);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ya, yb;
    bus.gecerli_i = 1'b0;
    bus.sonuc_hazir_i = 1'b0;
    drive(64'd0, 64'd0, 1'b0, 1'b0);

    @(negedge clk);
    chk("rst_sonuc", bus.sonuc_o, 64'd0);
    chk("rst_valid", 64'(bus.sonuc_gecerli_o), 64'd0);
    chk("rst_elde",  64'(bus.elde_o), 64'd0);
    chk("rst_tasma", 64'(bus.tasma_o), 64'd0);
    chk("rst_sifir", 64'(bus.sifir_o), 64'd0);
    chk("rst_hazir", 64'(bus.hazir_o), 64'd1);
    @(negedge clk);
    rstn = 1'b1;

    issue(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0); pop(0);
    issue(64'd5, 64'd5, 1'b1, 1'b0);                   pop(1);
    issue(64'd0, 64'd1, 1'b1, 1'b0);                   pop(0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0); pop(0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1); pop(0);
    issue(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1); pop(0);
    issue(64'd0, 64'd0, 1'b1, 1'b0);                   pop(0);

    // Back-pressure: result held, requests ignored while the consumer stalls
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      scramble();
      bus.gecerli_i = (i % 2 == 0);
      @(negedge clk);
      chk("bp_sonuc", bus.sonuc_o, e_sonuc);
      chk("bp_hazir", 64'(bus.hazir_o), 64'd0);
      chk("bp_valid", 64'(bus.sonuc_gecerli_o), 64'd1);
    end
    ya = {$urandom, $urandom};
    yb = {$urandom, $urandom};
    drive(ya, yb, 1'b1, 1'b0);
    bus.gecerli_i = 1'b1;
    bus.sonuc_hazir_i = 1'b1;
    @(negedge clk);
    bus.sonuc_hazir_i = 1'b0;
    chk("bp_rel_hazir", 64'(bus.hazir_o), 64'd1);
    chk("bp_rel_valid", 64'(bus.sonuc_gecerli_o), 64'd0);
    model(ya, yb, 1'b1, 1'b0, e_sonuc, e_elde, e_tasma, e_sifir);
    @(posedge clk);
    collect();
    pop(0);

    // Reset while the high half is being computed
    @(negedge clk);
    drive(64'hFFFF_0000_FFFF_0000, 64'h0000_1111_0000_1111, 1'b0, 1'b0);
    bus.gecerli_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.gecerli_i = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("ust_rst_sonuc", bus.sonuc_o, 64'd0);
    chk("ust_rst_valid", 64'(bus.sonuc_gecerli_o), 64'd0);
    chk("ust_rst_elde",  64'(bus.elde_o), 64'd0);
    chk("ust_rst_tasma", 64'(bus.tasma_o), 64'd0);
    chk("ust_rst_sifir", 64'(bus.sifir_o), 64'd0);
    chk("ust_rst_hazir", 64'(bus.hazir_o), 64'd1);
    @(negedge clk);
    chk("ust_rst_hold", 64'(bus.sonuc_gecerli_o), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(bus.sonuc_gecerli_o), 64'd0);
    chk("post_rst_hazir", 64'(bus.hazir_o), 64'd1);
    issue(64'd100, 64'd58, 1'b1, 1'b0); pop(0);

    for (int n = 0; n < 40; n++) begin
      issue(pick(), pick(), 1'($urandom), 1'($urandom));
      pop($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/genis_toplayici.md
Name: genis_toplayici

Overview:
Two-cycle 64-bit add/subtract unit that drives the team's 32-bit prefix adder (`toplayici`). It instantiates exactly one `toplayici` and time-multiplexes it: the low half is computed first, then the high half, with the carry held in a register between them. It sits upstream of the adder as its only operand/carry feeder, and downstream of the execute issue logic via a valid/ready handshake. Results leave through a second valid/ready handshake, together with carry, overflow and zero flags.

Parameters:
- None. Width is fixed at 64 bits, i.e. 2 × 32 bits, by the shared 32-bit adder.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rstn_i  input  1  asynchronous, active-low reset
- gecerli_i  input  1  request valid
- hazir_o  output  1  ready to accept a request
- islec0_i  input  64  operand A
- islec1_i  input  64  operand B
- cikar_i  input  1  0 = A+B, 1 = A−B
- sonuc_gecerli_o  output  1  result valid
- sonuc_hazir_i  input  1  consumer ready
- sonuc_o  output  64  result
- elde_o  output  1  carry out of bit 63 (for subtract: 1 = no borrow)
- tasma_o  output  1  signed overflow
- sifir_o  output  1  result == 0

Behaviour:
- FSM states: BOSTA, ALT, UST, CIKTI. Reset state is BOSTA.
- Reset values:
  - sonuc_o = 0, elde_o = 0, tasma_o = 0, sifir_o = 0, sonuc_gecerli_o = 0.
  - hazir_o = 1, since it is decoded from state BOSTA.
  - Internal carry register and operand registers = 0.
- hazir_o = (state == BOSTA). It is purely state-decoded, with no combinational path from sonuc_hazir_i.
- BOSTA:
  - On gecerli_i & hazir_o, latch A, B' = cikar_i ? ~islec1_i : islec1_i, and cin = cikar_i.
  - Next state: ALT.
  - Inputs may change freely after the accept edge.
- ALT:
  - Adder inputs: islec0_i = A[31:0], islec1_i = B'[31:0], carry_i = cin.
  - Register toplam_o into the low result half and carry_o into the carry register.
  - Next state: UST.
- UST:
  - Adder inputs: A[63:32], B'[63:32], carry_i = carry register.
  - Register the high result half.
  - elde_o = adder carry_o.
  - tasma_o = (A[63] == B'[63]) & (sum[63] != A[63]).
  - sifir_o = (final 64-bit result == 0).
  - Next state: CIKTI.
- CIKTI:
  - sonuc_gecerli_o = 1.
  - sonuc_o and the flags are held stable while sonuc_hazir_i = 0.
  - On sonuc_hazir_i, go to BOSTA and drop sonuc_gecerli_o on the next edge.
- Latency: accepted at edge k → sonuc_gecerli_o high after edge k+2.
- Minimum throughput: one operation per 4 cycles (accept, ALT, UST, CIKTI with immediate ready).
- Adder inputs are 0 in BOSTA and CIKTI so the adder does not toggle when idle.
- gecerli_i is ignored in every state other than BOSTA; no request is queued.
- Arithmetic wraps modulo 2^64.
- Subtraction is exactly A + ~B + 1. Consequences:
  - 0 − 0 gives elde_o = 1.
  - A − B with A < B (unsigned) gives elde_o = 0.
- sonuc_o, elde_o, tasma_o and sifir_o keep their last values after CIKTI until the next UST overwrites them. Consumers must qualify them with sonuc_gecerli_o.
- rstn_i asserted in any state:
  - Immediately returns to BOSTA and clears all registers and outputs.
  - The in-flight operation is dropped; no partial result is ever flagged valid.

Optional Feature:
- Macro: GENIS_TOPLAYICI_DOYUM_EN.
- When defined:
  - Adds port doyum_i (input, 1 bit), latched at the accept edge.
  - If doyum_i = 1 and tasma_o = 1, sonuc_o saturates: 0x7FFF_FFFF_FFFF_FFFF if A[63] = 0, else 0x8000_0000_0000_0000.
  - tasma_o and elde_o still report the raw (unsaturated) values.
  - sifir_o is evaluated on the saturated result.
- When undefined:
  - No doyum_i port.
  - Result always wraps.

Test Plan:
- Add 0x0000_0000_FFFF_FFFF + 0x1 → sonuc_o = 0x0000_0001_0000_0000, elde = 0, tasma = 0, sifir = 0. sonuc_gecerli_o rises exactly 2 edges after accept (checks inter-half carry).
- Subtract 0x5 − 0x5 → sonuc_o = 0, sifir = 1, elde = 1, tasma = 0.
- Subtract 0x0 − 0x1 → sonuc_o = 0xFFFF_FFFF_FFFF_FFFF, elde = 0, tasma = 0, sifir = 0.
- Add 0x7FFF_FFFF_FFFF_FFFF + 0x1, macro off → sonuc_o = 0x8000_0000_0000_0000, tasma = 1. Same operation with macro on and doyum_i = 1 → sonuc_o = 0x7FFF_FFFF_FFFF_FFFF, tasma = 1.
- Back-pressure: hold sonuc_hazir_i = 0 for 5 cycles in CIKTI while pulsing gecerli_i with new operands → sonuc_o is unchanged and hazir_o = 0 throughout. The new request is not taken until one cycle after sonuc_hazir_i = 1.
- Drop rstn_i to 0 while in UST → sonuc_gecerli_o stays 0 and all outputs read 0. After release, hazir_o = 1 and the next request completes normally.
